// File: rtl/lec_mpmem_pkg.sv
// Shared types and helpers for the multi-port reference memory.
package lec_mpmem_pkg;

    // Deepest read pipeline the memory supports.
    localparam int MAXRDLAT = 4;

    // Widest write-port set the winner helper can resolve.
    localparam int MAXWPRT = 16;

    // Ceiling log2. Returns 0 for values of 0 and 1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

    localparam int WINW = clog2(MAXWPRT);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Result of write-port arbitration for a single address.
    typedef struct packed {
        logic            hit;
        logic [WINW-1:0] idx;
    } wr_win_t;

    // Picks the highest-index port whose bit is set in match.
    // match[p] = write enable of port p AND its address equals the probed one.
    function automatic wr_win_t wr_winner(input logic [MAXWPRT-1:0] match);
        wr_win_t win;
        win = '0;
        for (int p = 0; p < MAXWPRT; p++) begin
            if (match[p]) begin
                win.hit = 1'b1;
                win.idx = WINW'(p);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/lec_rd_pipe.sv
// Per-port read pipeline: a valid/data shift register of depth RDLAT.
// At RDLAT = 0 it is a plain wire. Data stages load only when the valid
// bit entering them is set, so the output word holds between reads.
module lec_rd_pipe #(
    parameter int WIDTH = 24,
    parameter int RDLAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] dat_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] dat_out
);

    if (RDLAT == 0) begin : g_wire
        // Clock and reset have no use when the pipeline has no stages.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign vld_out        = vld_in;
        assign dat_out        = dat_in;
    end else begin : g_pipe
        logic [RDLAT-1:0] vld_q;
        logic [WIDTH-1:0] dat_q [RDLAT];

        // Shift valid every cycle; advance data only behind a valid bit.
        // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= '0;
                for (int i = 0; i < RDLAT; i++) dat_q[i] <= '0;
            end else begin
                vld_q[0] <= vld_in;
                if (vld_in) dat_q[0] <= dat_in;
                for (int i = 1; i < RDLAT; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
                end
            end
        end

        assign vld_out = vld_q[RDLAT-1];
        assign dat_out = dat_q[RDLAT-1];
    end

endmodule

// File: rtl/lec_mpmem_pipe_spec.sv
// Multi-port reference memory: NUMWPRT write ports, NUMRPRT read ports,
// 0..4 cycle read latency, optional write-first bypass, and a reset-time
// sweep that loads INITVAL into every word before the ports go live.
module lec_mpmem_pipe_spec
    import lec_mpmem_pkg::*;
#(
    parameter int               NUMWPRT = 4,
    parameter int               NUMRPRT = 4,
    parameter int               BITADDR = 6,
    parameter int               NUMADDR = 64,
    parameter int               WIDTH   = 24,
    parameter int               RDLAT   = 1,
    parameter int               BYPASS  = 0,
    parameter logic [WIDTH-1:0] INITVAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUMWPRT-1:0]         write,
    input  logic [NUMWPRT*BITADDR-1:0] wr_adr,
    input  logic [NUMWPRT*WIDTH-1:0]   din,
    input  logic [NUMRPRT-1:0]         read,
    input  logic [NUMRPRT*BITADDR-1:0] rd_adr,
    output logic [NUMRPRT*WIDTH-1:0]   rd_dout,
    output logic [NUMRPRT-1:0]         rd_vld,
    output logic                       ready,
    output logic                       wr_coll
);

    // Parameter sanity, rejected at elaboration.
    if (RDLAT < 0 || RDLAT > MAXRDLAT) begin : g_bad_rdlat
        $fatal(1, "lec_mpmem_pipe_spec: RDLAT out of range 0..4");
    end
    if (NUMADDR > (1 << BITADDR)) begin : g_bad_depth
        $fatal(1, "lec_mpmem_pipe_spec: NUMADDR exceeds 2**BITADDR");
    end
    if (NUMWPRT > MAXWPRT) begin : g_bad_wprt
        $fatal(1, "lec_mpmem_pipe_spec: too many write ports");
    end

    localparam logic [BITADDR-1:0] LASTADR = BITADDR'(NUMADDR - 1);

    logic [WIDTH-1:0]   mem [NUMADDR];
    logic [BITADDR-1:0] wa  [NUMWPRT];
    logic [WIDTH-1:0]   wd  [NUMWPRT];
    logic [BITADDR-1:0] ra  [NUMRPRT];
    logic [WIDTH-1:0]   rd_src [NUMRPRT];

    state_t             state_q, state_d;
    logic [BITADDR-1:0] cnt_q, cnt_d;
    logic               coll;
    logic               wr_coll_q;
    logic [MAXWPRT-1:0] match;
    wr_win_t            win;

    // Unpack the flat port buses into per-port views.
    for (genvar p = 0; p < NUMWPRT; p++) begin : g_wport
        assign wa[p] = wr_adr[p*BITADDR +: BITADDR];
        assign wd[p] = din[p*WIDTH +: WIDTH];
    end
    for (genvar r = 0; r < NUMRPRT; r++) begin : g_rport
        assign ra[r] = rd_adr[r*BITADDR +: BITADDR];
    end

    // FSM and sweep-counter register; reset restarts the sweep at address 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: step the sweep in INIT, go READY on the edge that writes the last word.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LASTADR) state_d = READY;
        end
    end

    assign ready = (state_q == READY);

    // Memory update: sweep word in INIT, port writes in READY (later port overrides earlier).
    // NOTE: the array has no reset; the init sweep gives it defined contents and keeps it RAM-like.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= INITVAL;
        end else begin
            for (int p = 0; p < NUMWPRT; p++) begin
                if (write[p] && int'(wa[p]) < NUMADDR) mem[wa[p]] <= wd[p];
            end
        end
    end

    // Collision detect: any two enabled write ports presenting the same address.
    always_comb begin
        coll = 1'b0;
        for (int p = 0; p < NUMWPRT; p++) begin
            for (int q = p + 1; q < NUMWPRT; q++) begin
                if (write[p] && write[q] && wa[p] == wa[q]) coll = 1'b1;
            end
        end
    end

    // Register the collision flag as a one-cycle pulse, only while live.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wr_coll_q <= 1'b0;
        else      wr_coll_q <= ready && coll;
    end

    assign wr_coll = wr_coll_q;

    // Read source per port: stored word, or same-cycle write data in bypass mode.
    always_comb begin
        match = '0;
        win   = '0;
        for (int r = 0; r < NUMRPRT; r++) begin
            rd_src[r] = '0;
            match     = '0;
            for (int p = 0; p < NUMWPRT; p++) begin
                match[p] = write[p] && (wa[p] == ra[r]);
            end
            win = wr_winner(match);
            if (int'(ra[r]) < NUMADDR) begin
                rd_src[r] = mem[ra[r]];
                if (BYPASS != 0 && ready && win.hit) begin
                    for (int p = 0; p < NUMWPRT; p++) begin
                        if (win.idx == WINW'(p)) rd_src[r] = wd[p];
                    end
                end
            end
        end
    end

    // One latency pipeline per read port.
    for (genvar r = 0; r < NUMRPRT; r++) begin : g_rd
        lec_rd_pipe #(
            .WIDTH (WIDTH),
            .RDLAT (RDLAT)
        ) u_pipe (
            .clk     (clk),
            .rst     (rst),
            .vld_in  (read[r] & ready),
            .dat_in  (rd_src[r]),
            .vld_out (rd_vld[r]),
            .dat_out (rd_dout[r*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_lec_mpmem_pipe_spec.sv
// Bench for lec_mpmem_pipe_spec. Three instances share one stimulus stream:
//   d0: RDLAT=3, read-first, 64 words
//   d1: RDLAT=2, write-first, 48 words (upper addresses out of range)
//   d2: RDLAT=0, read-first, 64 words
// A per-instance memory model pushes expected reads onto per-port queues
// tagged with the cycle they must appear in; outputs are sampled on negedge.
module tb_lec_mpmem_pipe_spec;

    localparam int ND = 3;
    localparam int NP = 4;
    localparam int W  = 24;
    localparam int BA = 6;
    localparam int LAT [ND] = '{3, 2, 0};
    localparam int BYP [ND] = '{0, 1, 0};
    localparam int NA  [ND] = '{64, 48, 64};
    localparam logic [W-1:0] IV = 24'h5A5A5A;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [NP-1:0]    write_v  = '0;
    logic [NP-1:0]    read_v   = '0;
    logic [NP*BA-1:0] wr_adr_v = '0;
    logic [NP*BA-1:0] rd_adr_v = '0;
    logic [NP*W-1:0]  din_v    = '0;

    logic [NP*W-1:0] dout_w  [ND];
    logic [NP-1:0]   vld_w   [ND];
    logic            ready_w [ND];
    logic            coll_w  [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        lec_mpmem_pipe_spec #(
            .NUMWPRT (NP),
            .NUMRPRT (NP),
            .BITADDR (BA),
            .NUMADDR (NA[g]),
            .WIDTH   (W),
            .RDLAT   (LAT[g]),
            .BYPASS  (BYP[g]),
            .INITVAL (IV)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .write   (write_v),
            .wr_adr  (wr_adr_v),
            .din     (din_v),
            .read    (read_v),
            .rd_adr  (rd_adr_v),
            .rd_dout (dout_w[g]),
            .rd_vld  (vld_w[g]),
            .ready   (ready_w[g]),
            .wr_coll (coll_w[g])
        );
    end

    // Stimulus for the current cycle.
    logic [NP-1:0] we, re;
    logic [BA-1:0] wa [NP];
    logic [BA-1:0] ra [NP];
    logic [W-1:0]  wd [NP];

    // Model state.
    logic [W-1:0] mem_m [ND][64];
    logic         rdy_m    [ND];
    int           initcnt  [ND];
    logic         coll_exp [ND];
    int           cyc = 0;

    typedef struct {
        int          due;
        logic [W-1:0] dat;
    } sb_t;
    sb_t sbq [ND*NP][$];

    int vld_cnt   [ND*NP];
    int first_vld [ND*NP];

    int total = 0;
    int bad   = 0;

    // Directed vectors: inputs plus the word d0 port 0 must return.
    typedef struct packed {
        logic [NP-1:0]        we;
        logic [NP-1:0][BA-1:0] wa;
        logic [NP-1:0][W-1:0]  wd;
        logic [NP-1:0]        re;
        logic [NP-1:0][BA-1:0] ra;
        logic [W-1:0]         exp0;
    } vec_t;
    localparam int NV = 10;
    vec_t vt [NV];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk1(input int wp, input logic [BA-1:0] a, input logic [W-1:0] d,
                                 input int rp, input logic [BA-1:0] r, input logic [W-1:0] e);
        vec_t v;
        v = '0;
        if (wp >= 0) begin
            v.we[wp] = 1'b1;
            v.wa[wp] = a;
            v.wd[wp] = d;
        end
        v.re[rp]  = 1'b1;
        v.ra[rp]  = r;
        v.exp0    = e;
        return v;
    endfunction

    function automatic logic [W-1:0] model_rd(input int d, input logic [BA-1:0] a);
        logic [W-1:0] v;
        if (int'(a) >= NA[d]) return '0;
        v = mem_m[d][a];
        if (BYP[d] != 0 && rdy_m[d]) begin
            for (int p = 0; p < NP; p++) begin
                if (we[p] && wa[p] == a) v = wd[p];
            end
        end
        return v;
    endfunction

    task automatic clear_in();
        we = '0;
        re = '0;
        for (int p = 0; p < NP; p++) begin
            wa[p] = '0;
            ra[p] = '0;
            wd[p] = '0;
        end
    endtask

    // One clock cycle: drive, predict, sample on negedge, advance model on posedge.
    task automatic tick(input logic use_ov = 1'b0, input logic [W-1:0] ov = '0);
        logic coll_now;
        logic exp_v;
        sb_t  e;
        int   k;
        write_v = we;
        read_v  = re;
        for (int p = 0; p < NP; p++) begin
            wr_adr_v[p*BA +: BA] = wa[p];
            rd_adr_v[p*BA +: BA] = ra[p];
            din_v[p*W +: W]      = wd[p];
        end
        coll_now = 1'b0;
        for (int p = 0; p < NP; p++) begin
            for (int q = p + 1; q < NP; q++) begin
                if (we[p] && we[q] && wa[p] == wa[q]) coll_now = 1'b1;
            end
        end
        for (int d = 0; d < ND; d++) begin
            for (int r = 0; r < NP; r++) begin
                if (re[r] && rdy_m[d]) begin
                    e.due = cyc + LAT[d];
                    e.dat = (use_ov && d == 0 && r == 0) ? ov : model_rd(d, ra[r]);
                    sbq[d*NP+r].push_back(e);
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("ready d%0d c%0d", d, cyc), W'(ready_w[d]), W'(rdy_m[d]));
            check($sformatf("wr_coll d%0d c%0d", d, cyc), W'(coll_w[d]), W'(coll_exp[d]));
            for (int r = 0; r < NP; r++) begin
                k     = d*NP + r;
                exp_v = (sbq[k].size() > 0) && (sbq[k][0].due == cyc);
                check($sformatf("rd_vld d%0d p%0d c%0d", d, r, cyc), W'(vld_w[d][r]), W'(exp_v));
                if (vld_w[d][r]) begin
                    vld_cnt[k]++;
                    if (first_vld[k] < 0) first_vld[k] = cyc;
                end
                if (exp_v) begin
                    e = sbq[k].pop_front();
                    check($sformatf("rd_dout d%0d p%0d c%0d", d, r, cyc), dout_w[d][r*W +: W], e.dat);
                end
            end
        end
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            if (rdy_m[d]) begin
                for (int p = 0; p < NP; p++) begin
                    if (we[p] && int'(wa[p]) < NA[d]) mem_m[d][wa[p]] = wd[p];
                end
                coll_exp[d] = coll_now;
            end else begin
                coll_exp[d] = 1'b0;
                initcnt[d]++;
                if (initcnt[d] == NA[d]) begin
                    rdy_m[d] = 1'b1;
                    for (int a = 0; a < 64; a++) mem_m[d][a] = IV;
                end
            end
        end
        cyc++;
        #1;
    endtask

    // Assert reset asynchronously, check the reset state, release after hold edges.
    task automatic do_reset(input int hold);
        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
            rdy_m[d]    = 1'b0;
            initcnt[d]  = 0;
            coll_exp[d] = 1'b0;
            for (int r = 0; r < NP; r++) sbq[d*NP+r].delete();
        end
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst ready d%0d", d), W'(ready_w[d]), '0);
            check($sformatf("rst wr_coll d%0d", d), W'(coll_w[d]), '0);
            check($sformatf("rst rd_vld d%0d", d), W'(vld_w[d]), '0);
            if (LAT[d] > 0) begin
                for (int r = 0; r < NP; r++) begin
                    check($sformatf("rst rd_dout d%0d p%0d", d, r), dout_w[d][r*W +: W], '0);
                end
            end
        end
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < ND*NP; k++) begin
            vld_cnt[k]   = 0;
            first_vld[k] = -1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_issue;

        vt[0] = mk1( 0,  9, 24'h111111, 0,  9, IV);
        vt[1] = mk1( 1,  7, 24'h000123, 0,  9, 24'h111111);
        vt[2] = mk1(-1,  0, 24'h000000, 0,  7, 24'h000123);
        vt[3] = mk1( 2,  9, 24'hABCDEF, 0,  9, 24'h111111);
        vt[4] = mk1( 0,  5, 24'h000001, 0,  9, 24'hABCDEF);
        vt[4].we[3] = 1'b1;
        vt[4].wa[3] = 6'd5;
        vt[4].wd[3] = 24'h000003;
        vt[5] = mk1(-1,  0, 24'h000000, 0,  5, 24'h000003);
        vt[6] = mk1(-1,  0, 24'h000000, 0,  0, IV);
        vt[7] = mk1(-1,  0, 24'h000000, 0, 63, IV);
        vt[8] = mk1( 1, 63, 24'h777777, 0, 63, IV);
        vt[9] = mk1(-1,  0, 24'h000000, 0, 63, 24'h777777);

        clear_in();
        clear_stats();
        do_reset(2);

        // Init sweep with reads of addr 0 and 63 held on: no valid before ready.
        re    = 4'b0011;
        ra[0] = 6'd0;
        ra[1] = 6'd63;
        repeat (66) tick();
        clear_in();
        repeat (5) tick();

        // Directed vectors: read-first/write-first, highest-port win, range.
        for (int i = 0; i < NV; i++) begin
            we = vt[i].we;
            re = vt[i].re;
            for (int p = 0; p < NP; p++) begin
                wa[p] = vt[i].wa[p];
                wd[p] = vt[i].wd[p];
                ra[p] = vt[i].ra[p];
            end
            tick(vt[i].re[0], vt[i].exp0);
        end
        clear_in();
        repeat (5) tick();

        // Latency: write addr 7, next cycle read on port 2 only.
        clear_stats();
        we[0] = 1'b1;
        wa[0] = 6'd7;
        wd[0] = 24'h000123;
        tick();
        clear_in();
        re[2]   = 1'b1;
        ra[2]   = 6'd7;
        t_issue = cyc;
        tick();
        clear_in();
        repeat (6) tick();
        check("latency d0 p2", W'(first_vld[0*NP+2] - t_issue), W'(3));
        check("latency d1 p2", W'(first_vld[1*NP+2] - t_issue), W'(2));
        check("latency d2 p2", W'(first_vld[2*NP+2] - t_issue), W'(0));
        check("latency d0 p0 idle", W'(first_vld[0*NP+0]), W'(-1));

        // Throughput: all ports read every cycle for 16 cycles.
        clear_stats();
        re = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            for (int p = 0; p < NP; p++) ra[p] = BA'(i + p*16);
            tick();
        end
        clear_in();
        repeat (6) tick();
        for (int d = 0; d < ND; d++) begin
            for (int p = 0; p < NP; p++) begin
                check($sformatf("burst count d%0d p%0d", d, p), W'(vld_cnt[d*NP+p]), W'(16));
            end
        end

        // Random traffic with frequent address overlap.
        repeat (60) begin
            we = NP'($urandom);
            re = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                wa[p] = ($urandom_range(0, 1) == 0) ? BA'($urandom_range(0, 7)) : BA'($urandom_range(0, 63));
                ra[p] = ($urandom_range(0, 1) == 0) ? BA'($urandom_range(0, 7)) : BA'($urandom_range(0, 63));
                wd[p] = W'($urandom);
            end
            tick();
        end
        clear_in();
        repeat (5) tick();

        // Give addr 9 and 20 distinctive contents before the reset sequence.
        we    = 4'b0011;
        wa[0] = 6'd9;
        wd[0] = 24'hCAFE00;
        wa[1] = 6'd20;
        wd[1] = 24'h0BEEF0;
        tick();
        clear_in();
        tick();

        // Reset mid-sweep at count 30, with writes, collisions and reads driven meanwhile.
        do_reset(1);
        we = 4'b1111;
        re = 4'b1111;
        for (int p = 0; p < NP; p++) begin
            wa[p] = 6'd9;
            ra[p] = 6'd9;
            wd[p] = 24'h123456;
        end
        repeat (30) tick();
        do_reset(2);
        clear_in();
        repeat (64) tick();
        re    = 4'b0011;
        ra[0] = 6'd9;
        ra[1] = 6'd20;
        tick(1'b1, IV);
        clear_in();
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lec_mpmem_pipe_spec.md
Name: lec_mpmem_pipe_spec

Overview:
Multi-port memory reference model: NUMWPRT write ports, NUMRPRT read ports, used as the golden side of equivalence and simulation checks.
- Read latency is parametrised from 0 to 4 cycles.
- Per-port read-valid outputs track each read through the pipeline.
- A selectable same-cycle write-to-read bypass mode is provided.
- A reset-time init sequencer sweeps every word to INITVAL and raises ready when done.

Parameters:
NUMWPRT, 4, number of write ports
NUMRPRT, 4, number of read ports
BITADDR, 6, address width
NUMADDR, 64, memory depth (must be <= 2**BITADDR)
WIDTH, 24, data width
RDLAT, 1, read latency in cycles, legal range 0..4
BYPASS, 0, 1 = write-first (same-cycle read of a written address returns new din); 0 = read-first (returns old word)
INITVAL, 0, WIDTH-bit value loaded into every word by the init sweep

Ports:
clk  input  1  clock; all state is updated on posedge
rst  input  1  asynchronous reset, active-low
write  input  [NUMWPRT-1:0]  per-port write enable
wr_adr  input  [BITADDR-1:0] x NUMWPRT  write address per port
din  input  [WIDTH-1:0] x NUMWPRT  write data per port
read  input  [NUMRPRT-1:0]  per-port read enable
rd_adr  input  [BITADDR-1:0] x NUMRPRT  read address per port
rd_dout  output  [WIDTH-1:0] x NUMRPRT  read data per port
rd_vld  output  [NUMRPRT-1:0]  rd_dout valid, per port
ready  output  1  init sweep complete; ports are live
wr_coll  output  1  registered pulse: two or more enabled write ports hit the same address in one cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to INIT; init address counter = 0.
  - ready=0, wr_coll=0, rd_vld=0; all rd_dout pipeline stages = 0.
  - Memory contents are not reset directly; the sweep overwrites them.
- FSM has two states, INIT and READY.
  - INIT: each posedge writes INITVAL to mem[cnt] and increments cnt.
  - On the posedge that writes NUMADDR-1, state goes to READY and ready goes to 1 (registered).
  - After rst deasserts, ready is therefore 1 after exactly NUMADDR posedges.
  - READY is held until the next reset.
  - Reset asserted mid-sweep or mid-operation aborts immediately; the sweep restarts at address 0 on release.
- In INIT, write, read and wr_coll detection are ignored; rd_vld stays 0.
- Writes (READY only): for each p with write[p]=1, mem[wr_adr[p]] <= din[p] at posedge.
  - When several ports target the same address, the highest port index wins.
  - A wr_adr >= NUMADDR is dropped silently.
- wr_coll: set for one cycle on the edge after any same-address multi-port write; it asserts regardless of whether the din values match.
- Read source, per port r, sampled in the cycle read[r]=1:
  - BYPASS=0: mem[rd_adr[r]] before that edge's writes.
  - BYPASS=1: if any write hits rd_adr[r] that cycle, the din of the highest-index matching port; otherwise the mem word.
  - rd_adr >= NUMADDR returns 0.
- Read timing:
  - RDLAT=0: rd_dout[r] and rd_vld[r]=read[r]&ready are combinational.
  - RDLAT=N>=1: read issued in cycle T gives rd_vld[r]=1 and data after posedge T+N-1, held for one cycle.
  - The pipeline accepts a new read every cycle per port, with no backpressure.
- When rd_vld[r]=0, rd_dout[r] holds its previous value.
  - Benches must check data only when rd_vld=1.
  - Reset forces rd_dout to 0.
- Out-of-range parameters (RDLAT>4, NUMADDR>2**BITADDR) stop elaboration via an elaboration-time assertion.

Decomposition:
- Package lec_mpmem_pkg:
  - function clog2;
  - state enum {INIT, READY};
  - constant MAXRDLAT=4;
  - function resolving highest-index write winner from write mask and address match.
- One sub-module: lec_rd_pipe, a per-port valid/data shift pipeline of depth RDLAT that degenerates to a wire at 0. Instantiate it NUMRPRT times in a generate loop.
- The memory array, FSM and collision detect stay in the top module.

Test Plan:
- Init: release rst, INITVAL=24'h5A5A5A, then read addr 0 and 63 -> ready rises after 64th posedge; rd_dout=24'h5A5A5A with rd_vld, and no rd_vld before ready.
- Latency: RDLAT=3, write 24'h000123 to addr 7, next cycle read port 2 addr 7 -> rd_vld[2]=1 with 24'h000123 exactly 3 cycles after issue; other ports' rd_vld=0.
- Bypass: same cycle write 24'hABCDEF to addr 9 (old 24'h111111) and read addr 9 -> BYPASS=0 returns 24'h111111; BYPASS=1 returns 24'hABCDEF.
- Collision: ports 0 and 3 write addr 5 with 24'h1 and 24'h3 -> wr_coll pulses 1 cycle; later read of addr 5 returns 24'h3.
- Reset mid-sweep: assert rst at init count 30, release -> ready low; ready rises 64 posedges after release; earlier writes are not observed.
- Throughput: RDLAT=2, back-to-back reads on all 4 ports for 16 cycles with incrementing addresses -> 16 consecutive valid pulses per port with matching data, no gaps.
